ad_ip_jesd204_tpl_adc_capture: RTL and testbench

AD_IP_JESD204_TPL_ADC_CAPTURE -- requirements
Module: ad_ip_jesd204_tpl_adc_capture

---
 rtl/ad_ip_jesd204_tpl_adc_capture.sv | 173 +++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_capture.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_capture.sv
// Triggered capture of TPL ADC beats into a first-word-fall-through FIFO with an AXI-Stream master.
// Define ADC_CAPTURE_TLAST_EN to carry a last-beat tag through the FIFO and drive m_axis_last.
//
// state   | meaning
// IDLE    | waiting for a cfg_enable rising edge
// ARMED   | length latched, holding off while adc_rst_sync is high
// CAPTURE | storing qualified beats until the latched length is counted
// DRAIN   | capture complete, emptying the FIFO to the stream
// DONE    | FIFO empty, holding until cfg_enable falls
module ad_ip_jesd204_tpl_adc_capture #(
    parameter int NUM_CHANNELS    = 1,
    parameter int DMA_DATA_WIDTH  = 64,
    parameter int FIFO_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_CHANNELS-1:0]   adc_valid,
    input  logic [DMA_DATA_WIDTH-1:0] adc_data,
    input  logic                      adc_rst_sync,
    input  logic                      cfg_enable,
    input  logic [31:0]               cfg_length,
    output logic                      m_axis_valid,
    input  logic                      m_axis_ready,
    output logic [DMA_DATA_WIDTH-1:0] m_axis_data,
    output logic                      m_axis_last,
    output logic                      status_busy,
    output logic                      status_done,
    output logic                      status_ovf
);

    localparam int AW = FIFO_ADDR_WIDTH;
`ifdef ADC_CAPTURE_TLAST_EN
    localparam int FW = DMA_DATA_WIDTH + 1;
`else
    localparam int FW = DMA_DATA_WIDTH;
`endif
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, DRAIN, DONE} state_t;

    state_t          state;
    logic            en_q;
    logic [31:0]     len_q;
    logic [31:0]     cnt_q;
    logic [31:0]     cnt_nxt;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic [FW-1:0]   mem [0:(1<<AW)-1];
    logic [FW-1:0]   wr_word;
    logic [FW-1:0]   rd_word;
    logic            empty;
    logic            full;
    logic            rd_fire;
    logic            beat_in;
    logic            wr_en;
    logic            start;
    logic            abort;
    logic            is_last;
    logic            valid_unused;

    // only channel 0 qualifies beats; the other valid bits are informational
    assign valid_unused = ^adc_valid;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign m_axis_valid = !empty;
    assign rd_fire = m_axis_valid && m_axis_ready;
    assign start   = cfg_enable && !en_q;
    assign abort   = !cfg_enable && (state == ARMED || state == CAPTURE || state == DRAIN);
    assign beat_in = (state == CAPTURE) && cfg_enable && adc_valid[0];
    // a full FIFO still accepts the beat when the head leaves in the same cycle
    assign wr_en   = beat_in && (!full || rd_fire);
    assign cnt_nxt = cnt_q + 32'd1;
    assign is_last = (cnt_nxt == len_q);
    assign rd_word = mem[rd_ptr[AW-1:0]];

`ifdef ADC_CAPTURE_TLAST_EN
    assign wr_word     = {is_last, adc_data};
    assign m_axis_data = rd_word[DMA_DATA_WIDTH-1:0];
    assign m_axis_last = m_axis_valid && rd_word[DMA_DATA_WIDTH];
`else
    assign wr_word     = adc_data;
    assign m_axis_data = rd_word;
    assign m_axis_last = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            en_q        <= 1'b0;
            len_q       <= 32'd0;
            cnt_q       <= 32'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            status_busy <= 1'b0;
            status_done <= 1'b0;
            status_ovf  <= 1'b0;
        end else begin
            en_q <= cfg_enable;
            if (abort) begin
                state       <= IDLE;
                status_busy <= 1'b0;
                status_done <= 1'b0;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (rd_fire) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                // dropped beats still advance the count so the capture length holds
                if (beat_in) begin
                    cnt_q <= cnt_nxt;
                    if (!wr_en) begin
                        status_ovf <= 1'b1;
                    end
                end
                case (state)
                    IDLE: begin
                        if (start) begin
                            state       <= ARMED;
                            status_busy <= 1'b1;
                            len_q       <= cfg_length;
                            cnt_q       <= 32'd0;
                            status_ovf  <= 1'b0;
                        end
                    end
                    ARMED: begin
                        if (len_q == 32'd0) begin
                            state       <= DONE;
                            status_busy <= 1'b0;
                            status_done <= 1'b1;
                        end else if (!adc_rst_sync) begin
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (beat_in && is_last) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (empty) begin
                            state       <= DONE;
                            status_busy <= 1'b0;
                            status_done <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (!cfg_enable) begin
                            state       <= IDLE;
                            status_done <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        status_busy <= 1'b0;
                        status_done <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_capture.sv
// Bench for ad_ip_jesd204_tpl_adc_capture: capture scenarios from a table, scoreboard on the stream,
// plus hand sequences for abort and mid-capture reset.
`timescale 1ns/1ps
module tb_ad_ip_jesd204_tpl_adc_capture;

    localparam int DW    = 64;
    localparam int AW    = 4;
    localparam int NCH   = 2;
    localparam int DEPTH = 1 << AW;
`ifdef ADC_CAPTURE_TLAST_EN
    localparam bit TLAST_EN = 1'b1;
`else
    localparam bit TLAST_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           resetn;
    logic [NCH-1:0] adc_valid;
    logic [DW-1:0]  adc_data;
    logic           adc_rst_sync;
    logic           cfg_enable;
    logic [31:0]    cfg_length;
    logic           m_axis_valid;
    logic           m_axis_ready;
    logic [DW-1:0]  m_axis_data;
    logic           m_axis_last;
    logic           status_busy;
    logic           status_done;
    logic           status_ovf;

    ad_ip_jesd204_tpl_adc_capture #(
        .NUM_CHANNELS   (NCH),
        .DMA_DATA_WIDTH (DW),
        .FIFO_ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .adc_valid    (adc_valid),
        .adc_data     (adc_data),
        .adc_rst_sync (adc_rst_sync),
        .cfg_enable   (cfg_enable),
        .cfg_length   (cfg_length),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_last  (m_axis_last),
        .status_busy  (status_busy),
        .status_done  (status_done),
        .status_ovf   (status_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        int len;
        int sync_cyc;
        int ready_on;
        int exp_beats;
        bit exp_ovf;
    } row_t;

    beat_t         sb[$];
    int            chk_cnt  = 0;
    int            pass_cnt = 0;
    int            out_cnt  = 0;
    logic          stall_q  = 1'b0;
    logic [DW-1:0] stall_data;
    logic          stall_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // stream monitor: pops the scoreboard on every transfer and checks hold-under-stall
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (stall_q && m_axis_valid) begin
                check("stall_data", m_axis_data, stall_data);
                check("stall_last", 64'(m_axis_last), 64'(stall_last));
            end
            stall_q    = m_axis_valid && !m_axis_ready;
            stall_data = m_axis_data;
            stall_last = m_axis_last;
            if (m_axis_valid && m_axis_ready) begin
                if (sb.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_beat: got data %0h expected no beat", m_axis_data);
                end else begin
                    e = sb.pop_front();
                    check("beat_data", m_axis_data, e.data);
                    check("beat_last", 64'(m_axis_last), 64'(e.last));
                    out_cnt++;
                end
            end
        end
    end

    task automatic run_row(input row_t r, input int ri);
        int  cap_start;
        int  last_c;
        int  occ;
        bit  rd;
        bit  wr;
        beat_t b;
        cap_start = ((r.sync_cyc > 1) ? r.sync_cyc : 1) + 1;
        last_c    = (((cap_start + r.len) > r.ready_on) ? (cap_start + r.len) : r.ready_on) + 2;
        occ       = 0;
        out_cnt   = 0;
        for (int c = 0; c <= last_c; c++) begin
            @(posedge clk); #1;
            cfg_enable   = 1'b1;
            cfg_length   = 32'(r.len);
            adc_valid    = 2'b01;
            adc_rst_sync = (c < r.sync_cyc);
            m_axis_ready = (c >= r.ready_on);
            adc_data     = {24'hC0FFEE, 8'(ri), 32'(c)};
            rd = m_axis_ready && (occ > 0);
            wr = 1'b0;
            if (c >= cap_start && c < cap_start + r.len) begin
                if (occ < DEPTH || rd) begin
                    b.data = adc_data;
                    b.last = TLAST_EN && ((c - cap_start) == r.len - 1);
                    sb.push_back(b);
                    wr = 1'b1;
                end
            end
            occ = occ + int'(wr) - int'(rd);
        end
        m_axis_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (status_done) break;
        end
        check($sformatf("row%0d_done", ri), 64'(status_done), 64'd1);
        check($sformatf("row%0d_busy", ri), 64'(status_busy), 64'd0);
        check($sformatf("row%0d_ovf", ri), 64'(status_ovf), 64'(r.exp_ovf));
        check($sformatf("row%0d_beats", ri), 64'(out_cnt), 64'(r.exp_beats));
        check($sformatf("row%0d_sb_left", ri), 64'(sb.size()), 64'd0);
        @(posedge clk); #1;
        cfg_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check($sformatf("row%0d_idle_done", ri), 64'(status_done), 64'd0);
        check($sformatf("row%0d_idle_busy", ri), 64'(status_busy), 64'd0);
    endtask

    // starts a 20-beat capture with ready low and stops after 5 beats are stored
    task automatic partial_capture(input int ri);
        for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            cfg_enable   = 1'b1;
            cfg_length   = 32'd20;
            adc_valid    = 2'b01;
            adc_rst_sync = 1'b0;
            m_axis_ready = 1'b0;
            adc_data     = {24'hBADBAD, 8'(ri), 32'(c)};
        end
        @(negedge clk);
        check("partial_valid", 64'(m_axis_valid), 64'd1);
        check("partial_busy", 64'(status_busy), 64'd1);
    endtask

    initial begin
        row_t rows[8];
        rows[0] = '{len: 8,  sync_cyc: 0,  ready_on: 0,  exp_beats: 8,  exp_ovf: 1'b0};
        rows[1] = '{len: 8,  sync_cyc: 10, ready_on: 0,  exp_beats: 8,  exp_ovf: 1'b0};
        rows[2] = '{len: 40, sync_cyc: 0,  ready_on: 60, exp_beats: 16, exp_ovf: 1'b1};
        rows[3] = '{len: 30, sync_cyc: 0,  ready_on: 18, exp_beats: 30, exp_ovf: 1'b0};
        rows[4] = '{len: 16, sync_cyc: 0,  ready_on: 40, exp_beats: 16, exp_ovf: 1'b0};
        rows[5] = '{len: 17, sync_cyc: 0,  ready_on: 40, exp_beats: 16, exp_ovf: 1'b1};
        rows[6] = '{len: 0,  sync_cyc: 0,  ready_on: 0,  exp_beats: 0,  exp_ovf: 1'b0};
        rows[7] = '{len: 1,  sync_cyc: 3,  ready_on: 0,  exp_beats: 1,  exp_ovf: 1'b0};

        resetn       = 1'b0;
        adc_valid    = '0;
        adc_data     = '0;
        adc_rst_sync = 1'b0;
        cfg_enable   = 1'b0;
        cfg_length   = 32'd0;
        m_axis_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(m_axis_valid), 64'd0);
        check("rst_last", 64'(m_axis_last), 64'd0);
        check("rst_busy", 64'(status_busy), 64'd0);
        check("rst_done", 64'(status_done), 64'd0);
        check("rst_ovf", 64'(status_ovf), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) begin
            run_row(rows[i], i);
        end

        // abort mid-capture: must be idle and empty one cycle later, then restart cleanly
        partial_capture(20);
        @(posedge clk); #1;
        cfg_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_busy", 64'(status_busy), 64'd0);
        check("abort_valid", 64'(m_axis_valid), 64'd0);
        run_row('{len: 3, sync_cyc: 0, ready_on: 0, exp_beats: 3, exp_ovf: 1'b0}, 21);

        // asynchronous reset mid-capture clears outputs without waiting for a clock
        partial_capture(22);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check("arst_valid", 64'(m_axis_valid), 64'd0);
        check("arst_last", 64'(m_axis_last), 64'd0);
        check("arst_busy", 64'(status_busy), 64'd0);
        check("arst_done", 64'(status_done), 64'd0);
        check("arst_ovf", 64'(status_ovf), 64'd0);
        cfg_enable   = 1'b0;
        m_axis_ready = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_valid", 64'(m_axis_valid), 64'd0);
        run_row('{len: 4, sync_cyc: 0, ready_on: 0, exp_beats: 4, exp_ovf: 1'b0}, 23);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
